// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: debounced active-low buttons drive mode, speed, run and reseed
// for a parametrised LED bank. Define LED_PWM_EN to add the 3-bit brightness PWM input.
module led_pattern_seq #(
  parameter int N_LED    = 12,
  parameter int TICK_DIV = 2097152,
  parameter int DEB_CNT  = 65536,
  parameter int N_BTN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] inpulse,
`ifdef LED_PWM_EN
  input  logic [2:0]       bright,
`endif
  output logic [N_LED-1:0] out,
  output logic [1:0]       mode,
  output logic [1:0]       speed,
  output logic             tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);
  localparam logic [N_LED-1:0] SEED_ONE = N_LED'(1);

  localparam logic [1:0] M_ROT_R  = 2'd0;
  localparam logic [1:0] M_ROT_L  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_FILL   = 2'd3;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:1] press;
  logic             run;
  logic             any_press;

  logic [N_LED-1:0] p;
  logic             dir;
  logic             fv;
  logic [TW-1:0]    pcnt;
  logic [TW-1:0]    term;
  logic             at_term;

  logic [N_LED-1:0] step_p;
  logic             step_dir;
  logic             step_fv;

  // Buttons are inverted on entry so everything downstream treats 1 as pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~inpulse;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [DW-1:0] cnt;
    logic          lvl;
    logic          accept;

    // cnt tracks how long sync2 has disagreed with the accepted level.
    assign accept = (sync2[i] != lvl) && (cnt == DEB_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= '0;
        lvl <= sync2[i];
      end else begin
        cnt <= cnt + DW'(1);
      end
    end

    if (i == 0) begin : g_run
      assign run = lvl;
    end else begin : g_press
      logic pr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pr <= 1'b0;
        else     pr <= accept & sync2[i];
      end
      assign press[i] = pr;
    end
  end

  assign any_press = |press;
  assign term      = TW'((TICK_DIV >> speed) - 1);
  assign at_term   = (pcnt == term);
  assign tick      = run && at_term && !any_press;

  // Next pattern for one step; an all-zero pattern outside FILL is treated as an upset.
  always_comb begin
    step_p   = p;
    step_dir = dir;
    step_fv  = fv;
    case (mode)
      M_ROT_R: begin
        if (p == '0) step_p = SEED_ONE;
        else         step_p = {p[0], p[N_LED-1:1]};
      end
      M_ROT_L: begin
        if (p == '0) step_p = SEED_ONE;
        else         step_p = {p[N_LED-2:0], p[N_LED-1]};
      end
      M_BOUNCE: begin
        if (p == '0) begin
          step_p   = SEED_ONE;
          step_dir = 1'b0;
        end else if (!dir) begin
          step_p = p << 1;
          if (step_p[N_LED-1]) step_dir = 1'b1;
        end else begin
          step_p = p >> 1;
          if (step_p[0]) step_dir = 1'b0;
        end
      end
      default: begin
        step_p = {p[N_LED-2:0], fv};
        if (&step_p)            step_fv = 1'b0;
        else if (step_p == '0)  step_fv = 1'b1;
      end
    endcase
  end

  // Presses win over a coinciding step; every press restarts the prescaler from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p     <= SEED_ONE;
      mode  <= M_ROT_R;
      speed <= 2'd0;
      dir   <= 1'b0;
      fv    <= 1'b1;
      pcnt  <= '0;
    end else if (press[1]) begin
      mode <= mode + 2'd1;
      p    <= (mode == M_BOUNCE) ? '0 : SEED_ONE;
      dir  <= 1'b0;
      fv   <= 1'b1;
      pcnt <= '0;
    end else if (press[3]) begin
      p    <= (mode == M_FILL) ? '0 : SEED_ONE;
      dir  <= 1'b0;
      fv   <= 1'b1;
      pcnt <= '0;
    end else if (press[2]) begin
      speed <= speed + 2'd1;
      pcnt  <= '0;
    end else if (run) begin
      if (at_term) begin
        pcnt <= '0;
        p    <= step_p;
        dir  <= step_dir;
        fv   <= step_fv;
      end else begin
        pcnt <= pcnt + TW'(1);
      end
    end
  end

`ifdef LED_PWM_EN
  logic [2:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= 3'd0;
    else     pwm_cnt <= pwm_cnt + 3'd1;
  end

  assign out = p & {N_LED{pwm_cnt < bright}};
`else
  assign out = p;
`endif

endmodule

// File: tb/tb_led_pattern_seq.sv
// Randomised bench for led_pattern_seq: a step-count model predicts every pattern,
// and tick spacing, first-tick latency, button debounce and async reset are checked.
module tb_led_pattern_seq;

  localparam int N_LED    = 4;
  localparam int TICK_DIV = 16;
  localparam int DEB_CNT  = 4;
  localparam int N_BTN    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_BTN-1:0] inpulse = '1;
  logic [N_LED-1:0] out;
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic             tick;

  led_pattern_seq #(
    .N_LED(N_LED), .TICK_DIV(TICK_DIV), .DEB_CNT(DEB_CNT), .N_BTN(N_BTN)
  ) dut (
    .clk(clk), .rst(rst), .inpulse(inpulse),
    .out(out), .mode(mode), .speed(speed), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int m_mode = 0;
  int m_speed = 0;
  int m_k = 0;
  int n_ticks = 0;
  bit pend = 0;
  int sess_start = 0;
  int last_tick = -1;
  bit sess_first = 0;
  bit sess_fresh = 1;
  int lat;
  int per;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pattern after k steps from a mode's seed, straight from the step rules.
  function automatic logic [N_LED-1:0] modelPattern(input int md, input int k);
    logic [N_LED-1:0] one;
    logic [N_LED-1:0] full;
    logic [N_LED-1:0] res;
    int pos;
    int ph;
    one  = 1;
    full = '1;
    case (md)
      0: begin
        pos = (N_LED - (k % N_LED)) % N_LED;
        res = one << pos;
      end
      1: begin
        pos = k % N_LED;
        res = one << pos;
      end
      2: begin
        ph  = k % (2 * N_LED - 2);
        pos = (ph < N_LED) ? ph : (2 * N_LED - 2 - ph);
        res = one << pos;
      end
      default: begin
        ph = k % (2 * N_LED);
        if (ph <= N_LED) res = full >> (N_LED - ph);
        else             res = full << (ph - N_LED);
      end
    endcase
    return res;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        checkOutput("step_out", out, modelPattern(m_mode, m_k));
        pend = 0;
      end
      if (tick) begin
        m_k++;
        n_ticks++;
        pend = 1;
        per = TICK_DIV >> m_speed;
        if (sess_first) begin
          lat = cyc - sess_start;
          if (sess_fresh)
            checkOutput($sformatf("first_tick_lat=%0d", lat),
                        (lat >= DEB_CNT + per - 1) && (lat <= DEB_CNT + per + 3), 1);
          else
            checkOutput($sformatf("resume_tick_lat=%0d", lat),
                        (lat >= DEB_CNT) && (lat <= DEB_CNT + per + 3), 1);
          sess_first = 0;
          sess_fresh = 0;
        end else if (last_tick >= 0) begin
          checkOutput("tick_period", cyc - last_tick, per);
        end
        last_tick = cyc;
      end
    end
  end

  task automatic applyStimulus(input int btn, input int hold);
    @(posedge clk);
    #1 inpulse[btn] = 1'b0;
    repeat (hold) @(posedge clk);
    #1 inpulse[btn] = 1'b1;
    repeat (DEB_CNT + 8) @(posedge clk);
  endtask

  task automatic checkState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_mode"}, mode, m_mode);
    checkOutput({tag, "_speed"}, speed, m_speed);
    checkOutput({tag, "_out"}, out, modelPattern(m_mode, m_k));
  endtask

  task automatic pressButton(input int btn);
    applyStimulus(btn, DEB_CNT + 6);
    case (btn)
      1: begin m_mode = (m_mode + 1) % 4; m_k = 0; end
      2: m_speed = (m_speed + 1) % 4;
      default: m_k = 0;
    endcase
    sess_fresh = 1;
    checkState($sformatf("press%0d", btn));
  endtask

  task automatic runSteps(input int n);
    int start;
    int bound;
    @(posedge clk);
    #1;
    start      = n_ticks;
    last_tick  = -1;
    sess_start = cyc;
    sess_first = 1;
    inpulse[0] = 1'b0;
    bound = (n + 1) * (TICK_DIV >> m_speed) + DEB_CNT + 20;
    for (int i = 0; i < bound && (n_ticks - start) < n; i++) @(posedge clk);
    checkOutput("run_steps_reached", (n_ticks - start) >= n, 1);
    #1 inpulse[0] = 1'b1;
    repeat (DEB_CNT + 8) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int op;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out", out, 1);
    checkOutput("reset_mode", mode, 0);
    checkOutput("reset_speed", speed, 0);
    checkOutput("reset_tick", tick, 0);
    rst = 1'b0;

    runSteps(4);
    pressButton(1);
    runSteps(4);
    pressButton(1);
    runSteps(8);
    pressButton(1);
    runSteps(9);

    applyStimulus(1, DEB_CNT - 1);
    checkState("glitch");

    pressButton(2);
    pressButton(2);
    pressButton(2);
    runSteps(6);
    pressButton(2);
    pressButton(3);
    pressButton(1);
    runSteps(3);

    for (int r = 0; r < 30; r++) begin
      op = $urandom_range(0, 5);
      if (op <= 2) runSteps($urandom_range(1, 6));
      else         pressButton(op - 2);
    end

    while (m_mode != 3)  pressButton(1);
    while (m_speed != 2) pressButton(2);
    @(posedge clk);
    #1;
    last_tick  = -1;
    sess_start = cyc;
    sess_first = 1;
    inpulse[0] = 1'b0;
    repeat (40) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_out", out, 1);
    checkOutput("async_rst_mode", mode, 0);
    checkOutput("async_rst_speed", speed, 0);
    checkOutput("async_rst_tick", tick, 0);
    inpulse = '1;
    m_mode = 0;
    m_speed = 0;
    m_k = 0;
    sess_first = 0;
    sess_fresh = 1;
    repeat (DEB_CNT + 4) @(posedge clk);
    #1 rst = 1'b0;
    runSteps(3);
    pressButton(1);
    runSteps(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
